// File: rtl/sim_ctrl.sv
// sim_ctrl: memory-mapped simulation-control slave.
// Software reports the end of a test (pass/fail, exit code, test number) over the bus.
// The block also provides a cycle watchdog, a console byte FIFO that the bench drains,
// and a programmable delayed pulse generator that drives the trap input.
// Optional feature macro: SIM_CTRL_CONSOLE_EN
//   defined   -> console FIFO, overflow flag and con_* handshake are built
//   undefined -> console writes are ignored, con_valid_o/con_data_o tie to 0,
//                and the FIFO count and overflow status bits read as 0
module sim_ctrl #(
    parameter int TIMEOUT_CYC = 30000,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel_i,
    input  logic        we_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        end_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [7:0]  code_o,
    output logic [31:0] testnum_o,
    output logic        con_valid_o,
    output logic [7:0]  con_data_o,
    input  logic        con_ready_i,
    output logic        trap_o
);

    localparam int               AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CW      = AW + 1;
    localparam bit               WDOG_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_TIMEOUT} state_e;
    typedef enum logic [1:0] {TRG_IDLE, TRG_WAIT, TRG_PULSE} trig_e;

    // ---------------- bus decode ----------------
    logic [2:0] reg_idx;
    logic       rd_en;
    logic       wr_status;
    logic       wr_testnum;
    logic       wr_console;
    logic       wr_trig;

    assign reg_idx    = addr_i[4:2];
    assign rd_en      = sel_i & ~we_i;
    assign wr_status  = sel_i & we_i & (reg_idx == 3'd0);
    assign wr_testnum = sel_i & we_i & (reg_idx == 3'd1);
    assign wr_console = sel_i & we_i & (reg_idx == 3'd2);
    assign wr_trig    = sel_i & we_i & (reg_idx == 3'd3);

    // ---------------- registers ----------------
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pass_q, pass_d;
    logic [7:0]        code_q, code_d;
    logic [31:0]       testnum_q, testnum_d;
    logic [31:0]       rdata_q, rdata_d;
    trig_e             trig_q, trig_d;
    logic [23:0]       dly_q, dly_d;
    logic [7:0]        wid_q, wid_d;

    // console status seen by the read mux (zero when the console is not built)
    logic [7:0]        fifo_cnt_rd;
    logic              ovf_rd;
    logic              trig_busy;

    assign trig_busy = (trig_q != TRG_IDLE);

    // End-of-test FSM and elapsed-cycle counter; an end request beats a same-cycle timeout
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        code_d    = code_q;
        testnum_d = testnum_q;
        if (wr_testnum) begin
            testnum_d = wdata_i;
        end
        if (state_q == ST_RUN) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (wr_status && wdata_i[0]) begin
                state_d = ST_DONE;
                pass_d  = wdata_i[1];
                code_d  = wdata_i[15:8];
            end else if (WDOG_EN && (cnt_q == TO_LAST)) begin
                state_d = ST_TIMEOUT;
                pass_d  = 1'b0;
                code_d  = 8'hFF;
            end
        end
    end

    // Read mux: data captured on the edge that samples the read strobe, held otherwise
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (reg_idx)
                3'd0:    rdata_d = {8'd0, fifo_cnt_rd, code_q, 4'd0, ovf_rd,
                                    (state_q == ST_TIMEOUT), pass_q, (state_q != ST_RUN)};
                3'd1:    rdata_d = testnum_q;
                3'd3:    rdata_d = {31'd0, trig_busy};
                3'd4:    rdata_d = 32'(cnt_q);
                default: rdata_d = 32'd0;
            endcase
        end
    end

    // Trap pulse generator: count down the delay, then hold the pulse for width cycles
    always_comb begin
        trig_d = trig_q;
        dly_d  = dly_q;
        wid_d  = wid_q;
        if (wr_trig) begin
            dly_d  = wdata_i[23:0];
            wid_d  = wdata_i[31:24];
            trig_d = (wdata_i[31:24] != 8'd0) ? TRG_WAIT : TRG_IDLE;
        end else begin
            case (trig_q)
                TRG_WAIT: begin
                    if (dly_q == 24'd0) begin
                        trig_d = TRG_PULSE;
                    end else begin
                        dly_d = dly_q - 24'd1;
                    end
                end
                TRG_PULSE: begin
                    if (wid_q == 8'd1) begin
                        trig_d = TRG_IDLE;
                    end else begin
                        wid_d = wid_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers for control, bus read data and trap generator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            pass_q    <= 1'b0;
            code_q    <= 8'd0;
            testnum_q <= 32'd0;
            rdata_q   <= 32'd0;
            trig_q    <= TRG_IDLE;
            dly_q     <= 24'd0;
            wid_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            code_q    <= code_d;
            testnum_q <= testnum_d;
            rdata_q   <= rdata_d;
            trig_q    <= trig_d;
            dly_q     <= dly_d;
            wid_q     <= wid_d;
        end
    end

    assign rdata_o   = rdata_q;
    assign end_o     = (state_q != ST_RUN);
    assign pass_o    = pass_q;
    assign timeout_o = (state_q == ST_TIMEOUT);
    assign code_o    = code_q;
    assign testnum_o = testnum_q;
    assign trap_o    = (trig_q == TRG_PULSE);

`ifdef SIM_CTRL_CONSOLE_EN
    // ---------------- console FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic          ovf_q, ovf_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          do_pop;
    logic          do_push;
    logic          unused_bits;

    assign fifo_empty = (fifo_cnt_q == CW'(0));
    assign fifo_full  = (fifo_cnt_q == CW'(FIFO_DEPTH));
    assign do_pop     = ~fifo_empty & con_ready_i;
    // a pop in the same cycle frees the slot, so a push into a full FIFO is still taken
    assign do_push    = wr_console & (~fifo_full | do_pop);
    assign unused_bits = ^addr_i[1:0];

    // Pointer, occupancy and sticky overflow update
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        ovf_d      = ovf_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            fifo_cnt_d = fifo_cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            fifo_cnt_d = fifo_cnt_q - CW'(1);
        end
        if (wr_status && wdata_i[3]) begin
            ovf_d = 1'b0;
        end else if (wr_console && !do_push) begin
            ovf_d = 1'b1;
        end
    end

    // FIFO control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every use
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q] <= wdata_i[7:0];
        end
    end

    assign con_valid_o = ~fifo_empty;
    assign con_data_o  = fifo_empty ? 8'd0 : fifo_mem[rd_ptr_q];
    assign fifo_cnt_rd = 8'(fifo_cnt_q);
    assign ovf_rd      = ovf_q;
`else
    logic unused_bits;

    assign unused_bits = ^{addr_i[1:0], con_ready_i, wr_console};
    assign con_valid_o = 1'b0;
    assign con_data_o  = 8'd0;
    assign fifo_cnt_rd = 8'd0;
    assign ovf_rd      = 1'b0;
`endif

endmodule

// File: tb/tb_sim_ctrl.sv
// tb_sim_ctrl: randomized and directed checking of sim_ctrl against a behavioural model.
// The model tracks test end by absolute cycle number, the console as a byte queue and the
// trap pulse as an absolute start/end cycle window.
module tb_sim_ctrl;

    localparam int TO    = 100;
    localparam int DEPTH = 8;
`ifdef SIM_CTRL_CONSOLE_EN
    localparam bit CON_EN = 1'b1;
`else
    localparam bit CON_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] wdata = 32'd0;
    logic        con_ready = 1'b0;
    logic [31:0] rdata_o;
    logic        end_o, pass_o, timeout_o, con_valid_o, trap_o;
    logic [7:0]  code_o, con_data_o;
    logic [31:0] testnum_o;

    sim_ctrl #(.TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .sel_i(sel), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata_o), .end_o(end_o), .pass_o(pass_o),
        .timeout_o(timeout_o), .code_o(code_o), .testnum_o(testnum_o),
        .con_valid_o(con_valid_o), .con_data_o(con_data_o),
        .con_ready_i(con_ready), .trap_o(trap_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h want=0x%08h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint      m_cyc;       // index of the last clock edge since reset release
    longint      m_pstart;    // first edge with trap high
    longint      m_pend;      // last edge with trap high / trigger busy
    bit          m_ended, m_pass, m_to, m_ovf;
    logic [7:0]  m_code;
    logic [31:0] m_cnt, m_tn, m_rdata;
    logic [7:0]  m_q[$];

    task automatic model_reset();
        m_cyc = 0; m_pstart = 0; m_pend = -1;
        m_ended = 0; m_pass = 0; m_to = 0; m_ovf = 0;
        m_code = 8'd0; m_cnt = 32'd0; m_tn = 32'd0; m_rdata = 32'd0;
        m_q.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a, input bit busy);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            3'd0: begin
                v[0]     = m_ended;
                v[1]     = m_pass;
                v[2]     = m_to;
                v[3]     = CON_EN ? m_ovf : 1'b0;
                v[15:8]  = m_code;
                v[23:16] = CON_EN ? 8'(m_q.size()) : 8'd0;
            end
            3'd1:    v = m_tn;
            3'd3:    v[0] = busy;
            3'd4:    v = m_cnt;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_edge();
        bit         rd_en, wr_en, busy_old;
        logic [2:0] a;
        m_cyc++;
        rd_en    = sel && !we;
        wr_en    = sel && we;
        a        = addr[4:2];
        busy_old = (m_cyc - 1) <= m_pend;
        if (rd_en) m_rdata = model_read(a, busy_old);
        if (!m_ended) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            if (wr_en && a == 3'd0 && wdata[0]) begin
                m_ended = 1; m_pass = wdata[1]; m_code = wdata[15:8];
            end else if (TO != 0 && m_cyc == TO) begin
                m_ended = 1; m_to = 1; m_pass = 0; m_code = 8'hFF;
            end
        end
        if (wr_en && a == 3'd1) m_tn = wdata;
        if (CON_EN) begin
            if (m_q.size() != 0 && con_ready) void'(m_q.pop_front());
            if (wr_en && a == 3'd2) begin
                if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]);
                else m_ovf = 1;
            end
            if (wr_en && a == 3'd0 && wdata[3]) m_ovf = 0;
        end
        if (wr_en && a == 3'd3) begin
            if (wdata[31:24] == 8'd0) begin
                m_pstart = 0; m_pend = -1;
            end else begin
                m_pstart = m_cyc + longint'(wdata[23:0]) + 1;
                m_pend   = m_cyc + longint'(wdata[23:0]) + longint'(wdata[31:24]);
            end
        end
    endtask

    task automatic compare_all();
        bit         exp_valid;
        logic [7:0] exp_data;
        exp_valid = CON_EN && (m_q.size() != 0);
        exp_data  = exp_valid ? m_q[0] : 8'd0;
        check("rdata",     rdata_o,     m_rdata);
        check("end",       end_o,       m_ended);
        check("pass",      pass_o,      m_pass);
        check("timeout",   timeout_o,   m_to);
        check("code",      code_o,      m_code);
        check("testnum",   testnum_o,   m_tn);
        check("con_valid", con_valid_o, exp_valid);
        check("con_data",  con_data_o,  exp_data);
        check("trap",      trap_o,      (m_cyc >= m_pstart) && (m_cyc <= m_pend));
    endtask

    // one clock edge: model follows the inputs sampled there, outputs checked 1 ns later
    task automatic step();
        bit         was_sel, was_we;
        logic [4:0] a;
        logic [31:0] d;
        @(posedge clk);
        was_sel = sel; was_we = we; a = addr; d = wdata;
        model_edge();
        #1;
        compare_all();
        if (was_sel)
            $display("TXN cyc=%0d %s addr=0x%02h data=0x%08h", m_cyc, was_we ? "WR" : "RD",
                     a, was_we ? d : rdata_o);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        sel = 1; we = 1; addr = a; wdata = d;
        step();
        sel = 0; we = 0;
    endtask

    task automatic rd(input logic [4:0] a);
        sel = 1; we = 0; addr = a;
        step();
        sel = 0;
    endtask

    // asynchronous reset asserted mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        check("rst_end",   end_o,       32'd0);
        check("rst_trap",  trap_o,      32'd0);
        check("rst_rdata", rdata_o,     32'd0);
        check("rst_valid", con_valid_o, 32'd0);
        check("rst_code",  code_o,      32'd0);
        check("rst_tnum",  testnum_o,   32'd0);
        model_reset();
        #2 rst_n = 1;
    endtask

    task automatic rand_inputs();
        logic [2:0] r3;
        r3    = 3'($urandom_range(0, 7));
        sel   = ($urandom_range(0, 9) < 4);
        we    = 1'($urandom_range(0, 1));
        addr  = {r3, 2'($urandom_range(0, 3))};
        wdata = $urandom();
        if (r3 == 3'd0) wdata[0] = ($urandom_range(0, 15) == 0);
        if (r3 == 3'd3) wdata = {8'($urandom_range(0, 6)), 24'($urandom_range(0, 10))};
        con_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        longint t, first;
        int     n;

        model_reset();
        @(posedge clk); #1;

        // end request: DONE with pass and code, later end writes ignored
        do_reset();
        wr(5'h04, 32'hCAFE_0001);
        wr(5'h00, 32'h0000_2A03);
        check("t1_end",  end_o,  32'd1);
        check("t1_pass", pass_o, 32'd1);
        check("t1_code", code_o, 32'h2A);
        wr(5'h00, 32'h0000_5501);
        check("t1_code_hold", code_o, 32'h2A);
        check("t1_pass_hold", pass_o, 32'd1);

        // watchdog expiry at edge TO, counter frozen afterwards
        do_reset();
        repeat (TO - 1) step();
        check("t2_not_yet", end_o, 32'd0);
        step();
        check("t2_end",     end_o,     32'd1);
        check("t2_timeout", timeout_o, 32'd1);
        check("t2_pass",    pass_o,    32'd0);
        check("t2_code",    code_o,    32'hFF);
        rd(5'h10);
        check("t2_cycles", rdata_o, 32'd100);
        repeat (5) step();
        rd(5'h10);
        check("t2_cycles_frozen", rdata_o, 32'd100);

        // end request in the same cycle as the watchdog: DONE wins
        do_reset();
        repeat (TO - 1) step();
        wr(5'h00, 32'h0000_1101);
        check("t2b_end",     end_o,     32'd1);
        check("t2b_timeout", timeout_o, 32'd0);
        check("t2b_code",    code_o,    32'h11);

        // trap pulse: delay 3, width 7
        do_reset();
        wr(5'h0C, 32'h0700_0003);
        t = m_cyc; first = -1; n = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (trap_o) begin
                if (first < 0) first = m_cyc;
                n++;
            end
        end
        check("t5_start", 32'(first - t), 32'd4);
        check("t5_width", 32'(n), 32'd7);
        // busy read, restart mid-wait, cancel mid-pulse
        wr(5'h0C, 32'h0300_0006);
        rd(5'h0C);
        check("t5_busy", rdata_o, 32'd1);
        step();
        wr(5'h0C, 32'h0400_0002);
        n = 0;
        while (!trap_o && n < 20) begin step(); n++; end
        check("t5_pulse_seen", trap_o, 32'd1);
        step();
        wr(5'h0C, 32'h0000_0000);
        check("t5_cancel", trap_o, 32'd0);
        rd(5'h0C);
        check("t5_idle", rdata_o, 32'd0);

`ifdef SIM_CTRL_CONSOLE_EN
        // overflow of a full FIFO, then drain in order
        do_reset();
        con_ready = 0;
        for (int i = 0; i < 9; i++) wr(5'h08, 32'(8'h41 + i));
        rd(5'h00);
        check("t3_count", 32'(rdata_o[23:16]), 32'd8);
        check("t3_ovf",   32'(rdata_o[3]),     32'd1);
        con_ready = 1;
        for (int i = 0; i < 8; i++) begin
            check("t3_byte", con_data_o, 32'(8'h41 + i));
            step();
        end
        check("t3_empty", con_valid_o, 32'd0);
        con_ready = 0;
        wr(5'h00, 32'h0000_0008);
        rd(5'h00);
        check("t3_ovf_clr", 32'(rdata_o[3]), 32'd0);

        // push and pop together on a full FIFO
        for (int i = 0; i < 8; i++) wr(5'h08, 32'(8'h61 + i));
        con_ready = 1;
        wr(5'h08, 32'h0000_005A);
        con_ready = 0;
        rd(5'h00);
        check("t4_count", 32'(rdata_o[23:16]), 32'd8);
        check("t4_ovf",   32'(rdata_o[3]),     32'd0);
        con_ready = 1;
        repeat (7) step();
        check("t4_last", con_data_o, 32'h5A);
        step();
        con_ready = 0;
`else
        // console absent: pushes are dropped silently
        do_reset();
        for (int i = 0; i < 3; i++) wr(5'h08, 32'(8'h78 + i));
        check("t6_valid", con_valid_o, 32'd0);
        rd(5'h00);
        check("t6_count", 32'(rdata_o[23:16]), 32'd0);
`endif

        // randomized phases, each started by an asynchronous reset
        for (int p = 0; p < 8; p++) begin
            do_reset();
            n = $urandom_range(60, 260);
            for (int i = 0; i < n; i++) begin
                rand_inputs();
                step();
            end
            sel = 0; we = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
